// File: rtl/led_sched_pkg.sv
// Shared types, field widths and helper functions for the LED blink scheduler.
package led_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ON      = 2'd1,
        OFF     = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

    // Width of the on-time / period fields, in ticks.
    localparam int unsigned MS_W    = 16;
    // Width of the repeat-count field.
    localparam int unsigned REP_W   = 8;
    // Largest supported number of requesters and the index width that covers it.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    // Result of a round-robin search.
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search upward from ptr for the first set request bit, wrapping modulo n_req.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int unsigned        n_req
    );
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= n_req) begin
                j = j - n_req;
            end
            if ((k < n_req) && !r.found && req[j[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = j[IDX_W-1:0];
            end
        end
        return r;
    endfunction

    // Effective period: max(period, on, 1), so a pattern always lasts at least one tick.
    function automatic logic [MS_W-1:0] eff_period(
        input logic [MS_W-1:0] on_t,
        input logic [MS_W-1:0] per_t
    );
        logic [MS_W-1:0] p;
        p = (per_t > on_t) ? per_t : on_t;
        if (p == '0) begin
            p = {{(MS_W-1){1'b0}}, 1'b1};
        end
        return p;
    endfunction

endpackage

// File: rtl/led_blink_scheduler_if.sv
// Requester-side bus of the LED blink scheduler: packed pattern requests in, grant/done/LED out.
interface led_blink_scheduler_if
    import led_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]       req;
    logic [MS_W*N_REQ-1:0]  on_ms;
    logic [MS_W*N_REQ-1:0]  period_ms;
    logic [REP_W*N_REQ-1:0] reps;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   sig;

    // Requesters drive patterns and observe the arbitration result.
    modport master (
        output req, on_ms, period_ms, reps,
        input  grant, done, busy, sig
    );

    // The scheduler consumes patterns and owns grant/done/busy and the LED.
    modport slave (
        input  req, on_ms, period_ms, reps,
        output grant, done, busy, sig
    );

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every PRESCALE clocks, with synchronous clear.
module led_tick_gen #(
    parameter int unsigned PRESCALE = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: hold at zero while cleared, otherwise wrap at PRESCALE-1.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the board LED: grants one requester at a time and plays its
// on/off blink pattern to completion before re-arbitrating.
module led_blink_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 27000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned N_REQ   = 4
) (
    input logic                  clk,
    input logic                  rst,
    led_blink_scheduler_if.slave bus
);

    localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    sched_state_t     state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic             sig_q, sig_d;
    logic [MS_W-1:0]  on_q, on_d;
    logic [MS_W-1:0]  off_q, off_d;
    logic [MS_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    logic             tick;
    logic             tick_clr;
    rr_pick_t         pick;
    logic [MS_W-1:0]  win_on, win_per, win_per_eff;
    logic [REP_W-1:0] win_reps;
    logic [MS_W-1:0]  tick_nxt;
    logic [REP_W-1:0] rep_nxt;
    logic             end_period;

    // The prescaler idles at zero outside a pattern so the first tick of a grant is exact.
    assign tick_clr = (state_q == IDLE) || (state_q == RELEASE);

    led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    assign pick = rr_pick(MAX_REQ'(bus.req), ptr_q, N_REQ);

    // Mux out the winning requester's pattern fields.
    always_comb begin
        win_on   = '0;
        win_per  = '0;
        win_reps = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick.idx == IDX_W'(i)) begin
                win_on   = bus.on_ms[MS_W*i +: MS_W];
                win_per  = bus.period_ms[MS_W*i +: MS_W];
                win_reps = bus.reps[REP_W*i +: REP_W];
            end
        end
        win_per_eff = eff_period(win_on, win_per);
    end

    // Next-state and registered-output logic of the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        done_d     = '0;
        busy_d     = busy_q;
        sig_d      = sig_q;
        on_d       = on_q;
        off_d      = off_q;
        reps_d     = reps_q;
        tick_cnt_d = tick_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        end_period = 1'b0;
        tick_nxt   = tick_cnt_q + 1'b1;
        rep_nxt    = rep_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    on_d       = win_on;
                    off_d      = win_per_eff - win_on;
                    reps_d     = win_reps;
                    grant_d    = ONE << pick.idx;
                    busy_d     = 1'b1;
                    ptr_d      = (pick.idx == LAST_IDX) ? '0 : pick.idx + 1'b1;
                    tick_cnt_d = '0;
                    rep_cnt_d  = '0;
                    if (win_reps == '0) begin
                        state_d = RELEASE;
                        sig_d   = 1'b0;
                    end else if (win_on == '0) begin
                        state_d = OFF;
                        sig_d   = 1'b0;
                    end else begin
                        state_d = ON;
                        sig_d   = 1'b1;
                    end
                end
            end
            ON: begin
                if (tick) begin
                    if (tick_nxt == on_q) begin
                        tick_cnt_d = '0;
                        if (off_q != '0) begin
                            state_d = OFF;
                            sig_d   = 1'b0;
                        end else begin
                            end_period = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_nxt;
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (tick_nxt == off_q) begin
                        tick_cnt_d = '0;
                        end_period = 1'b1;
                    end else begin
                        tick_cnt_d = tick_nxt;
                    end
                end
            end
            RELEASE: begin
                // A grant still held here (zero-rep pattern) is released now with its done pulse.
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                sig_d   = 1'b0;
                done_d  = grant_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_period) begin
            rep_cnt_d = rep_nxt;
            if (rep_nxt == reps_q) begin
                state_d = RELEASE;
                grant_d = '0;
                busy_d  = 1'b0;
                sig_d   = 1'b0;
                done_d  = grant_q;
            end else if (on_q != '0) begin
                state_d = ON;
                sig_d   = 1'b1;
            end else begin
                state_d = OFF;
                sig_d   = 1'b0;
            end
        end
    end

    // State, counter and output registers; reset clears everything with no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            sig_q      <= 1'b0;
            on_q       <= '0;
            off_q      <= '0;
            reps_q     <= '0;
            tick_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            sig_q      <= sig_d;
            on_q       <= on_d;
            off_q      <= off_d;
            reps_q     <= reps_d;
            tick_cnt_q <= tick_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.sig   = sig_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with PRESCALE = 1000/100 = 10 and four requesters.
module tb_led_blink_scheduler;
    import led_sched_pkg::*;

    localparam int unsigned N_REQ = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    led_blink_scheduler_if #(.N_REQ(N_REQ)) bus ();

    led_blink_scheduler #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .N_REQ  (N_REQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pat(input int i, input int on_t, input int per_t, input int rep_t);
        bus.on_ms[16*i +: 16]     = 16'(on_t);
        bus.period_ms[16*i +: 16] = 16'(per_t);
        bus.reps[8*i +: 8]        = 8'(rep_t);
    endtask

    // Wait (bounded) for a grant to appear, then check who got it.
    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        while (bus.grant == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.grant, exp);
    endtask

    // Starting at the first granted cycle, compare the LED against (c % per) < on for
    // `total` cycles, then check the release cycle. At cycle drop_at, req drops and
    // every on_ms field is rewritten, which must not disturb the running pattern.
    task automatic play_check(input string tag, input logic [3:0] g, input int on_cyc,
                              input int per_cyc, input int total, input int drop_at);
        int sig_bad;
        int grant_bad;
        sig_bad   = 0;
        grant_bad = 0;
        check({tag, "_busy"}, bus.busy, 1);
        for (int c = 0; c < total; c++) begin
            if (c == drop_at) begin
                bus.req   = '0;
                bus.on_ms = {N_REQ{16'd9}};
            end
            if (bus.sig !== ((c % per_cyc) < on_cyc)) sig_bad++;
            if (bus.grant !== g) grant_bad++;
            @(negedge clk);
        end
        check({tag, "_sig_bad_cycles"}, sig_bad, 0);
        check({tag, "_grant_bad_cycles"}, grant_bad, 0);
        check({tag, "_done"}, bus.done, g);
        check({tag, "_rel_grant"}, bus.grant, 0);
        check({tag, "_rel_sig"}, bus.sig, 0);
        check({tag, "_rel_busy"}, bus.busy, 0);
        @(negedge clk);
        check({tag, "_done_clr"}, bus.done, 0);
    endtask

    logic [3:0] rr_order [5];
    logic [3:0] done_seen;
    int         len;
    int         gap;
    int         n;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rr_order      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst           = 1'b0;
        bus.req       = '0;
        bus.on_ms     = '0;
        bus.period_ms = '0;
        bus.reps      = '0;

        // Reset state
        #1;
        check("rst_sig", bus.sig, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin: all four requesting, each 1 rep of on=1, period=2 (20 cycles)
        for (int i = 0; i < 4; i++) set_pat(i, 1, 2, 1);
        bus.req = 4'b1111;
        @(negedge clk);
        wait_grant("rr_first", rr_order[0]);
        for (int g = 0; g < 5; g++) begin
            check("rr_grant", bus.grant, rr_order[g]);
            if (g == 4) bus.req = '0;
            len = 0;
            while (bus.grant == rr_order[g] && len < 100) begin
                len++;
                @(negedge clk);
            end
            check("rr_len", len, 20);
            check("rr_done", bus.done, rr_order[g]);
            if (g < 4) begin
                gap = 1;
                @(negedge clk);
                while (bus.grant == '0 && gap < 50) begin
                    gap++;
                    @(negedge clk);
                end
                check("rr_gap", gap, 2);
            end
        end
        @(negedge clk);
        @(negedge clk);

        // Single requester: on=3, period=5, reps=2
        set_pat(0, 3, 5, 2);
        bus.req = 4'b0001;
        wait_grant("single_grant", 4'b0001);
        play_check("single", 4'b0001, 30, 50, 100, 0);

        // Zero reps: one grant cycle, then done, LED never lit
        set_pat(2, 5, 5, 0);
        bus.req = 4'b0100;
        wait_grant("rep0_grant", 4'b0100);
        check("rep0_sig_grant", bus.sig, 0);
        bus.req = '0;
        @(negedge clk);
        check("rep0_done", bus.done, 4'b0100);
        check("rep0_grant_clr", bus.grant, 0);
        check("rep0_sig_rel", bus.sig, 0);
        check("rep0_busy", bus.busy, 0);
        @(negedge clk);
        check("rep0_done_clr", bus.done, 0);

        // Zero on-time: dark for 40 cycles
        set_pat(3, 0, 4, 1);
        bus.req = 4'b1000;
        wait_grant("on0_grant", 4'b1000);
        play_check("on0", 4'b1000, 0, 40, 40, 0);

        // On-time longer than period: lit for exactly 70 cycles
        set_pat(0, 7, 5, 1);
        bus.req = 4'b0001;
        wait_grant("on7_grant", 4'b0001);
        play_check("on7", 4'b0001, 70, 70, 70, 0);

        // Reset during ON of requester 2
        set_pat(2, 5, 10, 3);
        bus.req = 4'b0100;
        wait_grant("mrst_grant", 4'b0100);
        repeat (3) @(negedge clk);
        check("mrst_pre_sig", bus.sig, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_sig", bus.sig, 0);
        check("mrst_grant", bus.grant, 0);
        check("mrst_busy", bus.busy, 0);
        done_seen = '0;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | bus.done;
        end
        check("mrst_no_done", done_seen, 0);
        for (int i = 0; i < 4; i++) set_pat(i, 1, 2, 1);
        bus.req = 4'b1111;
        rst     = 1'b1;
        @(negedge clk);
        check("mrst_first_grant", bus.grant, 4'b0001);
        bus.req = '0;
        n = 0;
        while (bus.done == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mrst_after_done", bus.done, 4'b0001);
        @(negedge clk);
        @(negedge clk);

        // Request drop mid-OFF plus on_ms change: requester 1, on=2, period=5, reps=2
        set_pat(1, 2, 5, 2);
        bus.req = 4'b0010;
        wait_grant("drop_grant", 4'b0010);
        play_check("drop", 4'b0010, 20, 50, 100, 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Round-robin scheduler that shares the single board LED among `N_REQ` requesters, each asking for a blink pattern given as on-time, period and repeat count. It owns the LED output and a millisecond time base derived from the 27 MHz board clock. It grants one requester at a time, plays that requester's pattern to completion without preemption, pulses `done`, then re-arbitrates. It sits between system status sources (heartbeat, error, button feedback) and the LED pin.

## Interface

- `CLK_HZ`, 27000000: clock frequency in Hz.
- `TICK_HZ`, 1000: time-base rate; `PRESCALE = CLK_HZ/TICK_HZ` (integer division, must be ≥ 1).
- `N_REQ`, 4: number of requesters, 2..8.
- `clk` in, 1: single clock; all logic on `posedge clk`.
- `rst` in, 1: asynchronous, active-low reset.
- `req` in, `N_REQ`: level request, one bit per requester.
- `on_ms` in, `16*N_REQ`: LED on-time in ticks; requester i is at `[16*i+15:16*i]`.
- `period_ms` in, `16*N_REQ`: pattern period in ticks, same packing.
- `reps` in, `8*N_REQ`: number of periods to play; requester i is at `[8*i+7:8*i]`.
- `grant` out, `N_REQ`: one-hot current owner, or all zero.
- `done` out, `N_REQ`: one-cycle pulse to the owner when its pattern ends.
- `busy` out, 1: high whenever `grant` is nonzero.
- `sig` out, 1: LED drive, registered.

## Operation

- Moore FSM with states IDLE, ON, OFF, RELEASE. All outputs are registered and depend only on state and counters.
- Reset values: state IDLE, `sig`=0, `grant`=0, `done`=0, `busy`=0, round-robin pointer=0, all counters 0.
- **IDLE**
  - If any `req` bit is set, select the winner by searching upward from `ptr`, wrapping modulo `N_REQ`.
  - Latch the winner's `on_ms`, `period_ms` and `reps`.
  - Set `grant` one-hot and set `ptr` to winner+1 (mod `N_REQ`).
  - Clear the prescaler, tick counter and rep counter.
- **Effective values**
  - `per_eff` = max(`period_ms`, `on_ms`, 1).
  - `off_eff` = `per_eff` − `on_ms`.
- **Leaving IDLE**
  - `reps`=0: go to RELEASE; `sig` stays 0.
  - `on_ms`=0: go to OFF.
  - Otherwise: go to ON.
- **ON**: `sig`=1. After `on_ms` ticks, go to OFF if `off_eff`>0. Otherwise end the period.
- **OFF**: `sig`=0. After `off_eff` ticks, end the period.
- **End of period**
  - Increment the rep counter.
  - If rep counter = `reps`, go to RELEASE.
  - Otherwise restart at ON, or at OFF if `on_ms`=0.
- **RELEASE** (one cycle): `sig`=0, `grant`=0, `done`[owner]=1, then go to IDLE.
- Latched values are frozen for the whole grant; input changes during a grant have no effect.
- Deasserting `req` mid-pattern is ignored: the pattern completes and `done` still pulses.
- A requester that keeps `req` high is served again only after all other active requesters have been served.
- Tick counter is 16 bits and rep counter is 8 bits, so maximum values fit without overflow.
- Prescaler width is `$clog2(PRESCALE)`; it wraps at `PRESCALE`−1 and produces a one-cycle tick.

## Timing

- `req` sampled high in IDLE at edge k: `grant` and `sig` (if ON) are valid after edge k+1.
- One tick = `PRESCALE` cycles. The prescaler restarts at 0 on grant, so edges are exact.
- ON lasts exactly `on_ms`×`PRESCALE` cycles; OFF lasts `off_eff`×`PRESCALE` cycles.
- Full pattern = `reps`×`per_eff`×`PRESCALE` cycles, followed by 1 RELEASE cycle.
- `done` is high in the RELEASE cycle only; `grant` is already low in that cycle.
- The earliest next grant is 2 cycles after the final pattern cycle (RELEASE, then IDLE).
- `rst` low at any time forces every output and the pointer to reset values immediately, with no `done` pulse. Operation resumes on the first edge after `rst` is released.

## Structure

- Package `led_sched_pkg` holds:
  - the state enum typedef `sched_state_t` (IDLE, ON, OFF, RELEASE) on 2 bits;
  - localparam field widths `MS_W`=16 and `REP_W`=8.
- Sub-module `led_tick_gen` (parameter `PRESCALE`):
  - ports `clk`, `rst`, `clr`, `tick`;
  - synchronous clear and a one-cycle tick.
- The round-robin search is a function in the package; it is not a separate module.

## Test plan

All scenarios use `CLK_HZ`=1000, `TICK_HZ`=100, so `PRESCALE`=10, and `N_REQ`=4.

- **Single requester.** `req`=0001, on=3, period=5, reps=2. Expect:
  - `grant`=0001 one cycle later;
  - `sig` pattern 1×30, 0×20, 1×30, 0×20;
  - then `done`=0001 for one cycle with `grant`=0.
- **Round-robin.** `req`=1111 held, all reps=1, on=1, period=2. Expect grants in the order 0001, 0010, 0100, 1000, 0001, with each grant lasting 20 cycles and a 2-cycle gap between grants.
- **Degenerate patterns.**
  - reps=0: `grant` for 1 cycle, then `done`, and `sig` never goes high.
  - on=0, period=4, reps=1: `sig` stays 0 for 40 cycles.
  - on=7, period=5, reps=1: `sig` is 1 for exactly 70 cycles.
- **Reset mid-pattern.** Drive `rst`=0 during ON of requester 2. Expect:
  - `sig`, `grant` and `busy` fall with no clock edge;
  - no `done` pulse;
  - after release with `req`=1111, the first grant is 0001.
- **Request drop.** Drop `req`[1] mid-OFF. Expect the pattern to finish with full timing and `done`=0010 to pulse. Changing `on_ms` mid-grant has no effect on the pattern.
